// File: rtl/servile_wb_arbiter.sv
// servile_wb_arbiter: shares one SRAM Wishbone slave port between the CPU
// instruction bus (ibus, read-only) and data bus (dbus). One master is granted
// per transaction; out-of-range addresses and stalled accesses are answered
// with err instead of ack. A DONE bubble after every transaction keeps the
// master's trailing stb from being re-arbitrated.
// Optional feature macro: SERVILE_ARB_ROUND_ROBIN_EN -- when defined, a tie in
// IDLE goes to the master that did not win the previous grant; otherwise dbus
// always has priority.
module servile_wb_arbiter #(
  parameter int AW      = 10,
  parameter int TIMEOUT = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [31:0]   i_wb_ibus_adr,
  input  logic          i_wb_ibus_stb,
  output logic [31:0]   o_wb_ibus_rdt,
  output logic          o_wb_ibus_ack,
  output logic          o_wb_ibus_err,
  input  logic [31:0]   i_wb_dbus_adr,
  input  logic [31:0]   i_wb_dbus_dat,
  input  logic [3:0]    i_wb_dbus_sel,
  input  logic          i_wb_dbus_we,
  input  logic          i_wb_dbus_stb,
  output logic [31:0]   o_wb_dbus_rdt,
  output logic          o_wb_dbus_ack,
  output logic          o_wb_dbus_err,
  output logic [AW-3:0] o_wb_mem_adr,
  output logic [31:0]   o_wb_mem_dat,
  output logic [3:0]    o_wb_mem_sel,
  output logic          o_wb_mem_we,
  output logic          o_wb_mem_stb,
  input  logic [31:0]   i_wb_mem_rdt,
  input  logic          i_wb_mem_ack
);

  // Counter only has to reach TIMEOUT-1.
  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
`ifdef SERVILE_ARB_ROUND_ROBIN_EN
  logic          last_dbus_q;  // 1: dbus won the most recent grant, 0: ibus
`endif

  logic        granted;
  logic        g_stb;
  logic [31:0] g_adr;
  logic        g_in_range;
  logic        timeout_hit;
  logic        resp_ack;
  logic        resp_err;
  logic        g_done;
  logic        pick_dbus;

  // Granted-master view, response decision and IDLE arbitration choice
  always_comb begin
    granted     = (state_q == GNT_I) || (state_q == GNT_D);
    g_adr       = (state_q == GNT_D) ? i_wb_dbus_adr : i_wb_ibus_adr;
    g_stb       = (state_q == GNT_D) ? i_wb_dbus_stb : i_wb_ibus_stb;
    g_in_range  = (g_adr >> AW) == 32'd0;
    timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);
    // A dropped stb ends the grant silently; ack beats a same-cycle timeout.
    resp_ack    = granted && g_stb && g_in_range && i_wb_mem_ack;
    resp_err    = granted && g_stb &&
                  (!g_in_range || (!i_wb_mem_ack && timeout_hit));
    g_done      = granted &&
                  (!g_stb || !g_in_range || i_wb_mem_ack || timeout_hit);
`ifdef SERVILE_ARB_ROUND_ROBIN_EN
    pick_dbus   = i_wb_dbus_stb && (!i_wb_ibus_stb || !last_dbus_q);
`else
    pick_dbus   = i_wb_dbus_stb;
`endif
  end

  // Arbitration FSM with wait counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
`ifdef SERVILE_ARB_ROUND_ROBIN_EN
      last_dbus_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pick_dbus) begin
            state_q     <= GNT_D;
`ifdef SERVILE_ARB_ROUND_ROBIN_EN
            last_dbus_q <= 1'b1;
`endif
          end else if (i_wb_ibus_stb) begin
            state_q     <= GNT_I;
`ifdef SERVILE_ARB_ROUND_ROBIN_EN
            last_dbus_q <= 1'b0;
`endif
          end
        end
        GNT_I, GNT_D: begin
          if (g_done) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Route the granted master to the slave and the slave response back to it
  always_comb begin
    o_wb_mem_adr  = '0;
    o_wb_mem_dat  = '0;
    o_wb_mem_sel  = '0;
    o_wb_mem_we   = 1'b0;
    o_wb_mem_stb  = 1'b0;
    o_wb_ibus_rdt = '0;
    o_wb_ibus_ack = 1'b0;
    o_wb_ibus_err = 1'b0;
    o_wb_dbus_rdt = '0;
    o_wb_dbus_ack = 1'b0;
    o_wb_dbus_err = 1'b0;
    if (!i_rst && granted) begin
      o_wb_mem_adr = g_adr[AW-1:2];
      o_wb_mem_stb = g_stb && g_in_range;
      if (state_q == GNT_D) begin
        o_wb_mem_dat  = i_wb_dbus_dat;
        o_wb_mem_sel  = i_wb_dbus_sel;
        o_wb_mem_we   = i_wb_dbus_we;
        o_wb_dbus_rdt = i_wb_mem_rdt;
        o_wb_dbus_ack = resp_ack;
        o_wb_dbus_err = resp_err;
      end else begin
        // ibus only reads whole words
        o_wb_mem_sel  = 4'hF;
        o_wb_ibus_rdt = i_wb_mem_rdt;
        o_wb_ibus_ack = resp_ack;
        o_wb_ibus_err = resp_err;
      end
    end
  end

endmodule

// File: tb/tb_servile_wb_arbiter.sv
// tb_servile_wb_arbiter: vector table, directed corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_servile_wb_arbiter;

  localparam int AW = 10;
  localparam int TO = 8;
`ifdef SERVILE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        i_clk, i_rst;
  logic [31:0] i_wb_ibus_adr;
  logic        i_wb_ibus_stb;
  logic [31:0] o_wb_ibus_rdt;
  logic        o_wb_ibus_ack, o_wb_ibus_err;
  logic [31:0] i_wb_dbus_adr, i_wb_dbus_dat;
  logic [3:0]  i_wb_dbus_sel;
  logic        i_wb_dbus_we, i_wb_dbus_stb;
  logic [31:0] o_wb_dbus_rdt;
  logic        o_wb_dbus_ack, o_wb_dbus_err;
  logic [7:0]  o_wb_mem_adr;
  logic [31:0] o_wb_mem_dat;
  logic [3:0]  o_wb_mem_sel;
  logic        o_wb_mem_we, o_wb_mem_stb;
  logic [31:0] i_wb_mem_rdt;
  logic        i_wb_mem_ack;

  servile_wb_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wb_ibus_adr(i_wb_ibus_adr), .i_wb_ibus_stb(i_wb_ibus_stb),
    .o_wb_ibus_rdt(o_wb_ibus_rdt), .o_wb_ibus_ack(o_wb_ibus_ack),
    .o_wb_ibus_err(o_wb_ibus_err),
    .i_wb_dbus_adr(i_wb_dbus_adr), .i_wb_dbus_dat(i_wb_dbus_dat),
    .i_wb_dbus_sel(i_wb_dbus_sel), .i_wb_dbus_we(i_wb_dbus_we),
    .i_wb_dbus_stb(i_wb_dbus_stb),
    .o_wb_dbus_rdt(o_wb_dbus_rdt), .o_wb_dbus_ack(o_wb_dbus_ack),
    .o_wb_dbus_err(o_wb_dbus_err),
    .o_wb_mem_adr(o_wb_mem_adr), .o_wb_mem_dat(o_wb_mem_dat),
    .o_wb_mem_sel(o_wb_mem_sel), .o_wb_mem_we(o_wb_mem_we),
    .o_wb_mem_stb(o_wb_mem_stb),
    .i_wb_mem_rdt(i_wb_mem_rdt), .i_wb_mem_ack(i_wb_mem_ack)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_wb_ibus_adr = '0; i_wb_ibus_stb = 1'b0;
    i_wb_dbus_adr = '0; i_wb_dbus_dat = '0; i_wb_dbus_sel = '0;
    i_wb_dbus_we = 1'b0; i_wb_dbus_stb = 1'b0;
    i_wb_mem_rdt = '0; i_wb_mem_ack = 1'b0;
  endtask

  // one cycle: drive just after posedge, caller checks at the following negedge
  task automatic cyc_start();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    idle_inputs();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      cyc_start();
      idle_inputs();
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " mem_stb"}, o_wb_mem_stb, 0);
    chk({tag, " ibus_ack"}, o_wb_ibus_ack, 0);
    chk({tag, " dbus_ack"}, o_wb_dbus_ack, 0);
    chk({tag, " ibus_err"}, o_wb_ibus_err, 0);
    chk({tag, " dbus_err"}, o_wb_dbus_err, 0);
  endtask

  typedef struct {
    logic        i_stb; logic [31:0] i_adr;
    logic        d_stb; logic [31:0] d_adr; logic [31:0] d_dat; logic [3:0] d_sel; logic d_we;
    logic        m_ack; logic [31:0] m_rdt;
    logic        e_stb; logic [7:0] e_adr; logic e_we;
    logic        e_iack; logic e_dack; logic e_ierr; logic e_derr;
    logic [31:0] e_irdt; logic [31:0] e_drdt;
  } vec_t;

  vec_t tbl[11];

  // timeout sequence: ibus waits, optional ack lands on the last allowed cycle
  task automatic timeout_seq(input bit ack_last);
    for (int c = 0; c <= 9; c++) begin
      cyc_start();
      idle_inputs();
      i_wb_ibus_stb = (c <= 8);
      i_wb_ibus_adr = 32'h30;
      i_wb_mem_ack  = ack_last && (c == 8);
      i_wb_mem_rdt  = 32'hA5A5_0000 + 32'(c);
      @(negedge i_clk);
      chk($sformatf("to%0d c%0d mem_stb", ack_last, c), o_wb_mem_stb, 32'((c >= 1) && (c <= 8)));
      chk($sformatf("to%0d c%0d ibus_err", ack_last, c), o_wb_ibus_err, 32'(!ack_last && (c == 8)));
      chk($sformatf("to%0d c%0d ibus_ack", ack_last, c), o_wb_ibus_ack, 32'(ack_last && (c == 8)));
    end
    idle_cycles(1);
  endtask

  // reference model state for the random phase (0 none, 1 ibus, 2 dbus)
  int owner, waited, last, m_pick;
  bit bubble, m_done;
  bit m_act[2], m_resp[2];
  int m_gap[2];

  initial begin
    i_rst = 1'b1;
    idle_inputs();
    // ---- reset state: outputs stay 0 even with requests and slave ack ----
    i_wb_ibus_stb = 1'b1; i_wb_dbus_stb = 1'b1; i_wb_dbus_adr = 32'h20;
    i_wb_dbus_we = 1'b1; i_wb_dbus_sel = 4'hF; i_wb_dbus_dat = 32'h1;
    i_wb_mem_ack = 1'b1; i_wb_mem_rdt = 32'hFFFF_FFFF;
    repeat (3) @(negedge i_clk);
    chk_quiet("rst");
    chk("rst mem_adr", o_wb_mem_adr, 0);
    chk("rst mem_we", o_wb_mem_we, 0);
    chk("rst mem_sel", o_wb_mem_sel, 0);
    chk("rst mem_dat", o_wb_mem_dat, 0);
    chk("rst ibus_rdt", o_wb_ibus_rdt, 0);
    chk("rst dbus_rdt", o_wb_dbus_rdt, 0);
    do_reset();

    // ---- vector table: single ibus read, then a fixed-priority tie ----
    tbl[0]  = '{1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEADBEEF,
                1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[3]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h55AA55AA,
                1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 32'h14, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1, 1'b0, 32'h0,
                1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[6]  = '{1'b1, 32'h14, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1, 1'b1, 32'h11112222,
                1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h11112222};
    tbl[7]  = '{1'b1, 32'h14, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0BAD0BAD,
                1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[8]  = '{1'b1, 32'h14, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 32'h14, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D,
                1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0};
    tbl[10] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    for (int k = 0; k < 11; k++) begin
      cyc_start();
      i_wb_ibus_stb = tbl[k].i_stb; i_wb_ibus_adr = tbl[k].i_adr;
      i_wb_dbus_stb = tbl[k].d_stb; i_wb_dbus_adr = tbl[k].d_adr;
      i_wb_dbus_dat = tbl[k].d_dat; i_wb_dbus_sel = tbl[k].d_sel;
      i_wb_dbus_we  = tbl[k].d_we;
      i_wb_mem_ack  = tbl[k].m_ack; i_wb_mem_rdt = tbl[k].m_rdt;
      @(negedge i_clk);
      chk($sformatf("tbl%0d mem_stb", k), o_wb_mem_stb, tbl[k].e_stb);
      chk($sformatf("tbl%0d mem_adr", k), o_wb_mem_adr, tbl[k].e_adr);
      chk($sformatf("tbl%0d mem_we", k), o_wb_mem_we, tbl[k].e_we);
      chk($sformatf("tbl%0d ibus_ack", k), o_wb_ibus_ack, tbl[k].e_iack);
      chk($sformatf("tbl%0d dbus_ack", k), o_wb_dbus_ack, tbl[k].e_dack);
      chk($sformatf("tbl%0d ibus_err", k), o_wb_ibus_err, tbl[k].e_ierr);
      chk($sformatf("tbl%0d dbus_err", k), o_wb_dbus_err, tbl[k].e_derr);
      chk($sformatf("tbl%0d ibus_rdt", k), o_wb_ibus_rdt, tbl[k].e_irdt);
      chk($sformatf("tbl%0d dbus_rdt", k), o_wb_dbus_rdt, tbl[k].e_drdt);
      if (tbl[k].e_we) begin
        chk($sformatf("tbl%0d mem_dat", k), o_wb_mem_dat, tbl[k].d_dat);
        chk($sformatf("tbl%0d mem_sel", k), o_wb_mem_sel, tbl[k].d_sel);
      end
      if (!tbl[k].e_stb) begin
        chk($sformatf("tbl%0d mem_dat0", k), o_wb_mem_dat, 0);
        chk($sformatf("tbl%0d mem_sel0", k), o_wb_mem_sel, 0);
      end
    end

    // ---- out-of-range dbus access ----
    for (int c = 0; c < 4; c++) begin
      cyc_start();
      idle_inputs();
      i_wb_dbus_stb = (c <= 1);
      i_wb_dbus_adr = 32'h400;
      i_wb_mem_ack  = 1'b1;
      @(negedge i_clk);
      chk($sformatf("oor c%0d mem_stb", c), o_wb_mem_stb, 0);
      chk($sformatf("oor c%0d dbus_err", c), o_wb_dbus_err, 32'(c == 1));
      chk($sformatf("oor c%0d dbus_ack", c), o_wb_dbus_ack, 0);
      chk($sformatf("oor c%0d ibus_err", c), o_wb_ibus_err, 0);
    end

    // ---- timeout, and ack arriving on the final cycle ----
    timeout_seq(1'b0);
    timeout_seq(1'b1);

    // ---- asynchronous reset during GNT_D ----
    cyc_start();
    idle_inputs();
    i_wb_dbus_stb = 1'b1; i_wb_dbus_adr = 32'h40; i_wb_dbus_we = 1'b1;
    cyc_start();
    @(negedge i_clk);
    chk("arst pre mem_stb", o_wb_mem_stb, 1);
    #1 i_rst = 1'b1;
    i_wb_mem_ack = 1'b1;
    #1;
    chk("arst mem_stb", o_wb_mem_stb, 0);
    chk("arst dbus_ack", o_wb_dbus_ack, 0);
    chk("arst dbus_err", o_wb_dbus_err, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      cyc_start();
      idle_inputs();
      i_wb_ibus_stb = (c <= 1);
      i_wb_ibus_adr = 32'h08;
      i_wb_mem_ack  = (c == 1);
      i_wb_mem_rdt  = 32'h0000_BEEF;
      @(negedge i_clk);
      chk($sformatf("post c%0d mem_stb", c), o_wb_mem_stb, 32'(c == 1));
      chk($sformatf("post c%0d ibus_ack", c), o_wb_ibus_ack, 32'(c == 1));
      if (c == 1) chk("post mem_adr", o_wb_mem_adr, 8'h02);
    end

    // ---- grant order with both masters requesting continuously ----
    begin
      bit drop_i, drop_d;
      int got;
      int order[4];
      do_reset();
      drop_i = 0; drop_d = 0; got = 0;
      for (int c = 0; c < 60 && got < 4; c++) begin
        cyc_start();
        idle_inputs();
        i_wb_ibus_stb = !drop_i; i_wb_ibus_adr = 32'h0;
        i_wb_dbus_stb = !drop_d; i_wb_dbus_adr = 32'h4;
        i_wb_mem_ack  = 1'b1;
        @(negedge i_clk);
        drop_i = o_wb_ibus_ack;
        drop_d = o_wb_dbus_ack;
        if (o_wb_dbus_ack && got < 4) begin order[got] = 2; got++; end
        if (o_wb_ibus_ack && got < 4) begin order[got] = 1; got++; end
      end
      chk("rr transactions", got, 4);
      for (int k = 0; k < got; k++)
        chk($sformatf("rr grant%0d (1=I,2=D)", k), order[k], (RR && (k % 2 == 1)) ? 1 : 2);
    end

    // ---- randomized traffic vs transaction-level model ----
    do_reset();
    owner = 0; waited = 0; last = 1; bubble = 0; m_done = 0; m_pick = 0;
    m_act = '{0, 0}; m_resp = '{0, 0}; m_gap = '{0, 0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit e_stb, e_ack[2], e_err[2], req, inr, ackin;
      logic [31:0] a;
      int g;
      @(posedge i_clk);
      if (owner != 0) begin
        if (m_done) begin owner = 0; bubble = 1; end
        else waited++;
      end else if (bubble) begin
        bubble = 0;
      end else if (m_pick != 0) begin
        owner = m_pick; waited = 0; last = m_pick;
      end
      #1;
      for (int m = 0; m < 2; m++) begin
        if (m_resp[m]) begin
          m_act[m] = 0; m_gap[m] = $urandom_range(0, 2);
        end else if (m_act[m]) begin
          if ($urandom_range(0, 31) == 0) m_act[m] = 0;
        end else if (m_gap[m] > 0) begin
          m_gap[m]--;
        end else if ($urandom_range(0, 1) == 1) begin
          m_act[m] = 1;
          a = ($urandom_range(0, 7) == 0) ? (32'h400 | ($urandom & 32'hFFFF_FC00))
                                          : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          if (m == 0) i_wb_ibus_adr = a;
          else begin
            i_wb_dbus_adr = a; i_wb_dbus_dat = $urandom;
            i_wb_dbus_sel = 4'($urandom); i_wb_dbus_we = 1'($urandom);
          end
        end
      end
      i_wb_ibus_stb = m_act[0];
      i_wb_dbus_stb = m_act[1];
      i_wb_mem_ack  = ($urandom_range(0, 5) == 0);
      i_wb_mem_rdt  = $urandom;
      @(negedge i_clk);
      e_stb = 0; e_ack = '{0, 0}; e_err = '{0, 0};
      m_done = 0; m_pick = 0; m_resp = '{0, 0};
      if (owner != 0) begin
        g     = owner - 1;
        a     = g ? i_wb_dbus_adr : i_wb_ibus_adr;
        req   = g ? i_wb_dbus_stb : i_wb_ibus_stb;
        inr   = (a >> AW) == 0;
        ackin = i_wb_mem_ack;
        e_stb = req && inr;
        if (!req) m_done = 1;
        else if (!inr) begin e_err[g] = 1; m_done = 1; end
        else if (ackin) begin e_ack[g] = 1; m_done = 1; end
        else if (waited == TO - 1) begin e_err[g] = 1; m_done = 1; end
        m_resp[g] = e_ack[g] || e_err[g];
        if (req && inr) begin
          chk($sformatf("rnd%0d mem_adr", cyc), o_wb_mem_adr, a[AW-1:2]);
          chk($sformatf("rnd%0d mem_we", cyc), o_wb_mem_we, g ? i_wb_dbus_we : 1'b0);
          if (g == 1) begin
            chk($sformatf("rnd%0d mem_dat", cyc), o_wb_mem_dat, i_wb_dbus_dat);
            chk($sformatf("rnd%0d mem_sel", cyc), o_wb_mem_sel, i_wb_dbus_sel);
          end
        end
        if (e_ack[g])
          chk($sformatf("rnd%0d gnt_rdt", cyc), g ? o_wb_dbus_rdt : o_wb_ibus_rdt, i_wb_mem_rdt);
        chk($sformatf("rnd%0d other_rdt", cyc), g ? o_wb_ibus_rdt : o_wb_dbus_rdt, 0);
      end else begin
        chk($sformatf("rnd%0d idle mem_adr", cyc), o_wb_mem_adr, 0);
        chk($sformatf("rnd%0d idle mem_dat", cyc), o_wb_mem_dat, 0);
        chk($sformatf("rnd%0d idle mem_sel", cyc), o_wb_mem_sel, 0);
        chk($sformatf("rnd%0d idle mem_we", cyc), o_wb_mem_we, 0);
        chk($sformatf("rnd%0d idle ibus_rdt", cyc), o_wb_ibus_rdt, 0);
        chk($sformatf("rnd%0d idle dbus_rdt", cyc), o_wb_dbus_rdt, 0);
        if (!bubble) begin
          if (i_wb_dbus_stb && i_wb_ibus_stb) m_pick = (RR && last == 2) ? 1 : 2;
          else if (i_wb_dbus_stb) m_pick = 2;
          else if (i_wb_ibus_stb) m_pick = 1;
        end
      end
      chk($sformatf("rnd%0d mem_stb", cyc), o_wb_mem_stb, e_stb);
      chk($sformatf("rnd%0d ibus_ack", cyc), o_wb_ibus_ack, e_ack[0]);
      chk($sformatf("rnd%0d dbus_ack", cyc), o_wb_dbus_ack, e_ack[1]);
      chk($sformatf("rnd%0d ibus_err", cyc), o_wb_ibus_err, e_err[0]);
      chk($sformatf("rnd%0d dbus_err", cyc), o_wb_dbus_err, e_err[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/servile_wb_arbiter.md
Name: servile_wb_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter sitting directly upstream of the RF/memory interface's Wishbone port (`i_wb_adr[9:2]` / `dat` / `sel` / `we` / `stb` → `rdt` / `ack`).
- Lets the CPU instruction bus (ibus) and data bus (dbus) share the single SRAM Wishbone port.
- Grants one master per transaction, performs an address range check, and aborts stalled accesses with a timeout error.

Parameters:
- AW, 10, byte-address width of the SRAM region (depth = 2**AW bytes); slave address is `[AW-1:2]`.
- TIMEOUT, 16, max cycles a granted access waits for slave ack; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_wb_ibus_adr  in  32  ibus byte address
- i_wb_ibus_stb  in  1  ibus request (read-only master)
- o_wb_ibus_rdt  out  32  ibus read data
- o_wb_ibus_ack  out  1  ibus ack
- o_wb_ibus_err  out  1  ibus error
- i_wb_dbus_adr  in  32  dbus byte address
- i_wb_dbus_dat  in  32  dbus write data
- i_wb_dbus_sel  in  4  dbus byte enables
- i_wb_dbus_we  in  1  dbus write enable
- i_wb_dbus_stb  in  1  dbus request
- o_wb_dbus_rdt  out  32  dbus read data
- o_wb_dbus_ack  out  1  dbus ack
- o_wb_dbus_err  out  1  dbus error
- o_wb_mem_adr  out  AW-2  slave word address (= granted `adr[AW-1:2]`)
- o_wb_mem_dat  out  32  slave write data
- o_wb_mem_sel  out  4  slave byte enables
- o_wb_mem_we  out  1  slave write enable
- o_wb_mem_stb  out  1  slave strobe
- i_wb_mem_rdt  in  32  slave read data
- i_wb_mem_ack  in  1  slave ack

Behaviour:
- **States:** IDLE, GNT_I, GNT_D, DONE. State is registered with asynchronous reset to IDLE. The timeout counter resets to 0. The `last_grant` register resets to IBUS.
- **Output reset values:** all outputs are 0 while `i_rst` is high. Slave-side outputs are muxed from the granted master. In IDLE and DONE, `o_wb_mem_stb`, `we`, `sel` and `dat` are 0, and `adr` is 0.
- **IDLE arbitration:**
  - Fixed priority: dbus over ibus.
  - The selected stb moves the state to GNT_D or GNT_I on the next edge, and the counter is cleared.
  - No requests: stay in IDLE.
- **GNT_x, address in range** (granted `adr[31:AW]` == 0):
  - `o_wb_mem_stb` = granted master's stb; the other signals are passed through combinationally.
  - When `i_wb_mem_ack` is high: the granted master's ack = 1 in the same cycle, rdt = `i_wb_mem_rdt`, next state = DONE.
- **GNT_x, address out of range:**
  - `o_wb_mem_stb` = 0.
  - Granted master's err = 1 in the first GNT cycle; next state = DONE.
- **Timeout** (TIMEOUT > 0):
  - The counter increments each GNT cycle without ack.
  - If the counter == TIMEOUT-1 and there is no ack that cycle: err = 1 for that cycle, `o_wb_mem_stb` is still high, next state = DONE. Slave stb is therefore high for exactly TIMEOUT cycles.
  - Ack and timeout in the same cycle: ack wins and err stays 0.
- **Master drops stb while granted** (protocol violation): `o_wb_mem_stb` follows it low, no ack/err, next state = DONE.
- **DONE:** one mandatory bubble cycle; no grant, slave stb low; next state = IDLE. This ensures the master's stb, which drops the cycle after ack/err, is never re-arbitrated.
- **Response routing:**
  - ack/err are combinational and are asserted only in GNT_x.
  - Only the granted master ever sees ack/err.
  - rdt to the non-granted master = 0.
- **Latency:** request in IDLE at cycle 0 → slave stb in cycle 1 → ack in the cycle the slave acks. Back-to-back transactions from one master are spaced by at least 3 cycles (GNT, DONE, IDLE).
- **`last_grant`:** updated on every entry to GNT_x.
- **Reset mid-transaction:** slave stb is forced to 0 immediately, no ack/err, state = IDLE.

Optional Feature:
- `SERVILE_ARB_ROUND_ROBIN_EN`
- **Defined:** when both stb are high in IDLE, grant the master that did not win `last_grant`. After reset `last_grant` = IBUS, so dbus wins the first tie. A single requester is always granted.
- **Undefined:** fixed dbus priority, and `last_grant` is unused.

Test Plan:
- **Single ibus read:** ibus stb, adr=0x10; slave acks 1 cycle after stb with rdt=0xDEADBEEF → `o_wb_mem_adr`=0x04, `we`=0, `o_wb_ibus_ack`=1 with rdt=0xDEADBEEF in the slave-ack cycle; dbus ack/err stay 0.
- **Tie under fixed priority:** both stb high in cycle 0; dbus write adr=0x20, dat=0x12345678, sel=0xF → dbus is served first (mem adr=0x08, we=1), ibus is granted after DONE+IDLE, and each ack is seen exactly once.
- **Round robin:** with `SERVILE_ARB_ROUND_ROBIN_EN`, both masters hold requests for 4 transactions → grant order D, I, D, I. Without the macro the order is D, D, D, D until dbus stops requesting.
- **Out-of-range access:** dbus adr=0x400 (AW=10) → `o_wb_mem_stb` never rises, `o_wb_dbus_err`=1 in the first GNT cycle (cycle 1), then DONE, then IDLE.
- **Timeout:** TIMEOUT=8, slave never acks → `o_wb_mem_stb` high for cycles 1–8, `o_wb_ibus_err`=1 in cycle 8, stb low in cycle 9. Ack arriving in cycle 8 instead → ack=1, err=0.
- **Reset mid-transaction:** assert `i_rst` asynchronously during GNT_D → `o_wb_mem_stb` drops without waiting for a clock edge and no ack is issued. After release, a new ibus request is granted normally.
